// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero shortcut and pipeline-flush abort.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIVZ = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 accept;
  logic                 divz;
  logic                 iter_done;
  logic [WIDTH-1:0]     dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;

  assign accept    = (state_q == S_IDLE) && start_i && !annul_i;
  assign divz      = (divisor_i == '0);
  assign iter_done = (cnt_q == CNT_W'(WIDTH));
  assign dvd_mag   = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign dvs_mag   = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // quo_q doubles as the dividend shift register: MSBs leave as quotient bits enter.
  // The partial remainder stays below the divisor, so bit WIDTH of diff is a valid borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = divz ? S_DIVZ : S_RUN;
      S_DIVZ: state_d = annul_i ? S_IDLE : S_DONE;
      S_RUN: begin
        if (annul_i)        state_d = S_IDLE;
        else if (iter_done) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != S_IDLE);
    ready_o  = (state_q == S_DONE);
    result_o = result_q;
  end

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          negq_d = signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          negr_d = signed_i && dividend_i[WIDTH-1];
          cnt_d  = '0;
          rem_d  = '0;
          dvs_d  = dvs_mag;
          // Divide-by-zero returns the raw dividend as remainder.
          quo_d  = divz ? dividend_i : dvd_mag;
        end
      end
      S_DIVZ: begin
        if (!annul_i) result_d = {quo_q, {WIDTH{1'b1}}};
      end
      S_RUN: begin
        if (!annul_i) begin
          if (iter_done) begin
            result_d = {(negr_q ? -rem_q : rem_q), (negq_q ? -quo_q : quo_q)};
          end else begin
            rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

endmodule
